// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter and sequencer for the register file's single write port.
// Owners keep the port for a whole burst. A watchdog revokes an owner that stalls too long.
module regfile_write_arbiter #(
  parameter int unsigned HOLD_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req0_last,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  input  logic        req1_last,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  // Handshake: a beat transfers on a rising edge where valid and ready are both high.
  // Ready is decoded from state only, so it never depends on valid in the same cycle.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_owner_q, last_owner_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        revoke;

  logic        cur_id;
  logic        cur_valid;
  logic        cur_last;
  logic [4:0]  cur_addr;
  logic [31:0] cur_data;
  logic        accept;

  // State register
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_cnt_d   = hold_cnt_q;
    revoke       = 1'b0;
    case (state_q)
      IDLE: begin
        hold_cnt_d = 8'd0;
        if (req0_valid && req1_valid) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (req0_valid) begin
          state_d = OWN0;
        end else if (req1_valid) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (cur_valid) begin
          hold_cnt_d = 8'd0;
          if (cur_last) begin
            state_d      = IDLE;
            last_owner_d = cur_id;
          end
        end else if (hold_cnt_q == HOLD_LIMIT) begin
          // Stalled owner loses the port; any beats already written stay written.
          state_d      = IDLE;
          last_owner_d = cur_id;
          hold_cnt_d   = 8'd0;
          revoke       = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode and beat mux
  always_comb begin
    req0_ready = (state_q == OWN0);
    req1_ready = (state_q == OWN1);
    owner      = {req1_ready, req0_ready};
    cur_id     = (state_q == OWN1);
    cur_valid  = cur_id ? req1_valid : req0_valid;
    cur_last   = cur_id ? req1_last  : req0_last;
    cur_addr   = cur_id ? req1_addr  : req0_addr;
    cur_data   = cur_id ? req1_data  : req0_data;
    accept     = (req0_ready && req0_valid) || (req1_ready && req1_valid);
  end

  // Registered write port; r0 beats are consumed but never strobed.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
      timeout_err      <= 1'b0;
    end else begin
      ctrl_writeEnable <= accept && (cur_addr != 5'd0);
      timeout_err      <= revoke;
      if (accept && (cur_addr != 5'd0)) begin
        ctrl_writeReg <= cur_addr;
        data_writeReg <= cur_data;
      end
    end
  end

endmodule
